// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver with mid-bit sampling, false-start
// rejection, parity/stop checking and a valid/ready character output with overrun.
module uart_rx_core #(
    parameter int CLK_DIV   = 10417,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state, state_next;
    logic                 rx_meta, rxs;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr_acc, ferr_acc;
    logic                 shift_en, par_en, stop_en, deliver;
    logic                 stop_bad, par_calc;

    assign stop_bad = ferr_acc | ~rxs;
    assign par_calc = ^{shift_reg, rxs};
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_next;
        end
    end

    // cnt restarts on every state entry and after every sample; bit_cnt counts
    // data bits in DATA and stop bits in STOP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        bit_next   = bit_cnt;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        deliver    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (!rxs) state_next = S_START;
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    shift_en = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt == FULL_LAST) begin
                    cnt_next   = '0;
                    par_en     = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    stop_en  = 1'b1;
                    if (bit_cnt == STOP_LAST) begin
                        bit_next   = '0;
                        deliver    = 1'b1;
                        state_next = stop_bad ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_next = '0;
                if (rxs) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                bit_next   = '0;
            end
        endcase
        // Disabling abandons any partial frame without producing flags or data.
        if (!rx_en) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            bit_next   = '0;
            shift_en   = 1'b0;
            par_en     = 1'b0;
            stop_en    = 1'b0;
            deliver    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (shift_en) shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            if (state == S_START) begin
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (par_en) perr_acc <= (PARITY == 1) ? ~par_calc : par_calc;
            if (stop_en && !rxs) ferr_acc <= 1'b1;
            overrun <= 1'b0;
            // A held character is only replaced if it is being consumed this cycle.
            if (deliver) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift_reg;
                    parity_err <= perr_acc;
                    frame_err  <= stop_bad;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: drives serial frames into an 8N1 receiver and an even-parity,
// two-stop receiver, and checks delivered characters against a frame-level model.
module tb_uart_rx_core;
    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rx_en, rxd_line, ready;

    logic [7:0] d0, d1;
    logic       v0, pe0, fe0, ov0, busy0;
    logic       v1, pe1, fe1, ov1, busy1;

    int tests = 0;
    int fails = 0;
    int ov_cnt0 = 0;
    int busy_cnt0 = 0;

    logic [9:0] q0[$], q1[$], exp_q[$];

    always #5 clk = ~clk;

    uart_rx_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en[0]), .rxd(rxd_line[0]),
        .data_out(d0), .data_valid(v0), .data_ready(ready[0]),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(busy0)
    );

    uart_rx_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en[1]), .rxd(rxd_line[1]),
        .data_out(d1), .data_valid(v1), .data_ready(ready[1]),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(busy1)
    );

    // Record every completed handshake as {parity_err, frame_err, data}.
    always @(negedge clk) begin
        if (v0 && ready[0]) q0.push_back({pe0, fe0, d0});
        if (v1 && ready[1]) q1.push_back({pe1, fe1, d1});
        if (ov0) ov_cnt0++;
        if (busy0) busy_cnt0++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int dut, input logic [7:0] data, input logic has_par,
                                  input logic par_bit, input logic [1:0] stops, input int nstop);
        logic [15:0] frame;
        int n;
        frame = '0;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[1+i] = data[i];
        n = 9;
        if (has_par) begin
            frame[n] = par_bit;
            n++;
        end
        for (int s = 0; s < nstop; s++) frame[n+s] = stops[s];
        n += nstop;
        for (int i = 0; i < n; i++) begin
            rxd_line[dut] = frame[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic check_char(input int dut, input string tag, input logic [9:0] exp);
        logic [9:0] got;
        int sz;
        sz = (dut == 0) ? q0.size() : q1.size();
        check_output({tag, " present"}, 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            got = (dut == 0) ? q0.pop_front() : q1.pop_front();
            check_output(tag, 32'(got), 32'(exp));
        end
    endtask

    task automatic drain_expected(input int dut, input string tag);
        int sz;
        sz = (dut == 0) ? q0.size() : q1.size();
        check_output({tag, " count"}, 32'(sz), 32'(exp_q.size()));
        while (exp_q.size() > 0) check_char(dut, tag, exp_q.pop_front());
    endtask

    task automatic partial_frame();
        rxd_line[0] = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd_line[0] = i[0];
            repeat (DIV) @(negedge clk);
        end
        rxd_line[0] = 1'b0;
        repeat (DIV / 2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; rx_en = 2'b11; rxd_line = 2'b11; ready = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        check_output("reset data_out", 32'(d0), 32'h0);
        check_output("reset data_valid", 32'(v0), 32'h0);
        check_output("reset flags", 32'({pe0, fe0, ov0}), 32'h0);
        check_output("reset busy", 32'(busy0), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Back-to-back 0xA5 / 0x3C with a handshake-ready consumer.
        apply_stimulus(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1);
        apply_stimulus(0, 8'h3C, 1'b0, 1'b0, 2'b11, 1);
        repeat (2 * DIV) @(negedge clk);
        check_char(0, "b2b first", {2'b00, 8'hA5});
        check_char(0, "b2b second", {2'b00, 8'h3C});
        check_output("b2b no extra", 32'(q0.size()), 32'd0);
        check_output("b2b valid low", 32'(v0), 32'd0);

        // Random 8N1 frames, some with a low stop bit.
        for (int f = 0; f < 8; f++) begin
            logic [7:0] b;
            logic ok;
            int gap;
            b = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            apply_stimulus(0, b, 1'b0, 1'b0, {1'b1, ok}, 1);
            exp_q.push_back({1'b0, ~ok, b});
            gap = ok ? $urandom_range(0, 4) : $urandom_range(1, 8);
            rxd_line[0] = 1'b1;
            repeat (gap) @(negedge clk);
        end
        repeat (2 * DIV) @(negedge clk);
        drain_expected(0, "rand 8N1");

        // Even parity: 0x07 has odd weight, so parity bit 0 is wrong and 1 is right.
        apply_stimulus(1, 8'h07, 1'b1, 1'b0, 2'b11, 2);
        apply_stimulus(1, 8'h07, 1'b1, 1'b1, 2'b11, 2);
        repeat (2 * DIV) @(negedge clk);
        check_char(1, "parity bad", {2'b10, 8'h07});
        check_char(1, "parity good", {2'b00, 8'h07});

        for (int f = 0; f < 6; f++) begin
            logic [7:0] b;
            logic p;
            logic [1:0] st;
            int gap;
            b = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            apply_stimulus(1, b, 1'b1, p, st, 2);
            exp_q.push_back({1'(($countones({b, p}) % 2) != 0), ~(st[0] & st[1]), b});
            gap = st[1] ? $urandom_range(0, 4) : $urandom_range(1, 8);
            rxd_line[1] = 1'b1;
            repeat (gap) @(negedge clk);
        end
        repeat (2 * DIV) @(negedge clk);
        drain_expected(1, "rand 8E2");

        // Glitch shorter than half a bit is rejected after exactly half a bit of busy.
        busy_cnt0 = 0;
        rxd_line[0] = 1'b0;
        repeat (5) @(negedge clk);
        rxd_line[0] = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check_output("false start busy cycles", 32'(busy_cnt0), 32'(DIV / 2));
        check_output("false start idle", 32'(busy0), 32'd0);
        check_output("false start no data", 32'(q0.size()), 32'd0);

        // Low stop bit followed by a break: held in WAIT_HIGH until the line recovers.
        apply_stimulus(0, 8'h55, 1'b0, 1'b0, 2'b00, 1);
        repeat (2 * DIV) @(negedge clk);
        check_output("break busy", 32'(busy0), 32'd1);
        repeat (DIV) @(negedge clk);
        rxd_line[0] = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check_output("break released", 32'(busy0), 32'd0);
        check_char(0, "break char", {2'b01, 8'h55});
        check_output("break no spurious", 32'(q0.size()), 32'd0);

        // Overrun: consumer stalled across two deliveries.
        @(posedge clk); #1 ready[0] = 1'b0;
        ov_cnt0 = 0;
        apply_stimulus(0, 8'h11, 1'b0, 1'b0, 2'b11, 1);
        apply_stimulus(0, 8'h22, 1'b0, 1'b0, 2'b11, 1);
        repeat (DIV) @(negedge clk);
        check_output("overrun held data", 32'(d0), 32'h11);
        check_output("overrun valid", 32'(v0), 32'd1);
        check_output("overrun pulse cycles", 32'(ov_cnt0), 32'd1);
        @(posedge clk); #1 ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        check_output("overrun valid cleared", 32'(v0), 32'd0);
        check_char(0, "overrun char", {2'b00, 8'h11});

        // Reset during bit 4 clears outputs immediately.
        partial_frame();
        rst_n = 1'b0;
        #1;
        check_output("midreset data_out", 32'(d0), 32'h0);
        check_output("midreset valid", 32'(v0), 32'd0);
        check_output("midreset busy", 32'(busy0), 32'd0);
        rxd_line[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV) @(negedge clk);
        check_output("midreset no data", 32'(q0.size()), 32'd0);
        apply_stimulus(0, 8'h81, 1'b0, 1'b0, 2'b11, 1);
        repeat (2 * DIV) @(negedge clk);
        check_char(0, "after reset 0x81", {2'b00, 8'h81});

        // Disable during bit 4: back to IDLE on the next edge, nothing delivered.
        partial_frame();
        rx_en[0] = 1'b0;
        @(negedge clk);
        check_output("disable idle", 32'(busy0), 32'd0);
        rxd_line[0] = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check_output("disable no data", 32'(q0.size()), 32'd0);
        check_output("disable keeps output", 32'(d0), 32'h81);
        rx_en[0] = 1'b1;
        apply_stimulus(0, 8'h81, 1'b0, 1'b0, 2'b11, 1);
        repeat (2 * DIV) @(negedge clk);
        check_char(0, "after disable 0x81", {2'b00, 8'h81});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
